// File: rtl/gate_selftest_ctrl.sv
// Exhaustive self-test sequencer for a 7-function logic unit (AND..NOT, 28 vectors).
// Optional macro SELFTEST_STOP_ON_FAIL_EN: end the sweep at the first mismatch.
module gate_selftest_ctrl #(
    parameter int SETTLE_CYC = 1,
    parameter int ERR_W      = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [2:0]       lu_op,
    output logic             lu_a,
    output logic             lu_b,
    input  logic             lu_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [2:0]       fail_op,
    output logic [1:0]       fail_vec
);

    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

    state_t           state_r;
    logic [2:0]       op_r;
    logic [1:0]       vec_r;
    logic [3:0]       settle_r;
    logic             exp_s;
    logic             mismatch_s;
    logic             last_s;
    logic             stop_s;
    logic [ERR_W-1:0] err_next_s;
    logic [2:0]       op_next_s;
    logic [1:0]       vec_next_s;

    function automatic logic expected_y(input logic [2:0] op, input logic a, input logic b);
        logic y;
        case (op)
            3'd0:    y = a & b;
            3'd1:    y = a | b;
            3'd2:    y = ~(a & b);
            3'd3:    y = ~(a | b);
            3'd4:    y = a ^ b;
            3'd5:    y = ~(a ^ b);
            3'd6:    y = ~a;
            default: y = 1'b0;
        endcase
        return y;
    endfunction

    // Compare logic and next-vector computation for the CHECK state
    always_comb begin
        exp_s      = expected_y(op_r, vec_r[1], vec_r[0]);
        mismatch_s = (lu_y != exp_s);
        if (mismatch_s && (err_cnt != {ERR_W{1'b1}})) begin
            err_next_s = err_cnt + {{(ERR_W-1){1'b0}}, 1'b1};
        end else begin
            err_next_s = err_cnt;
        end
        last_s     = (op_r == 3'd6) && (vec_r == 2'd3);
        vec_next_s = vec_r + 2'd1;
        if (vec_r == 2'd3) begin
            op_next_s = op_r + 3'd1;
        end else begin
            op_next_s = op_r;
        end
    end

`ifdef SELFTEST_STOP_ON_FAIL_EN
    assign stop_s = mismatch_s;
`else
    assign stop_s = 1'b0;
`endif

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            op_r     <= 3'd0;
            vec_r    <= 2'd0;
            settle_r <= 4'd0;
            lu_op    <= 3'd0;
            lu_a     <= 1'b0;
            lu_b     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= '0;
            fail_op  <= 3'd0;
            fail_vec <= 2'd0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        err_cnt  <= '0;
                        fail_op  <= 3'd0;
                        fail_vec <= 2'd0;
                        done     <= 1'b0;
                        pass     <= 1'b0;
                        op_r     <= 3'd0;
                        vec_r    <= 2'd0;
                        settle_r <= 4'd0;
                        lu_op    <= 3'd0;
                        lu_a     <= 1'b0;
                        lu_b     <= 1'b0;
                        busy     <= 1'b1;
                        state_r  <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_r == SETTLE_LAST) begin
                        settle_r <= 4'd0;
                        state_r  <= CHECK;
                    end else begin
                        settle_r <= settle_r + 4'd1;
                    end
                end
                CHECK: begin
                    err_cnt <= err_next_s;
                    // err_cnt saturates and never wraps, so zero means no earlier mismatch
                    if (mismatch_s && (err_cnt == '0)) begin
                        fail_op  <= op_r;
                        fail_vec <= vec_r;
                    end
                    if (last_s || stop_s) begin
                        op_r    <= 3'd0;
                        vec_r   <= 2'd0;
                        lu_op   <= 3'd0;
                        lu_a    <= 1'b0;
                        lu_b    <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (err_next_s == '0);
                        state_r <= DONE;
                    end else begin
                        op_r    <= op_next_s;
                        vec_r   <= vec_next_s;
                        lu_op   <= op_next_s;
                        lu_a    <= vec_next_s[1];
                        lu_b    <= vec_next_s[0];
                        state_r <= SETTLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_selftest_ctrl.sv
// Scoreboard bench for gate_selftest_ctrl with a configurable faulty logic-unit model.
module tb_gate_selftest_ctrl;

    localparam int SETTLE_CYC = 1;
    localparam int ERR_W      = 5;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic [2:0]       lu_op;
    logic             lu_a;
    logic             lu_b;
    logic             lu_y;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_cnt;
    logic [2:0]       fail_op;
    logic [1:0]       fail_vec;

    int n_cmp   = 0;
    int n_fail  = 0;
    int lu_mode = 0;   // 0 correct, 1 stuck-at-0, 2 XOR/XNOR swapped

    typedef struct {
        int         err;
        logic [2:0] fop;
        logic [1:0] fvec;
        logic       pass;
        int         nvec;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    gate_selftest_ctrl #(.SETTLE_CYC(SETTLE_CYC), .ERR_W(ERR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .lu_op(lu_op), .lu_a(lu_a), .lu_b(lu_b), .lu_y(lu_y),
        .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .fail_op(fail_op), .fail_vec(fail_vec)
    );

    // truth-table nibble indexed by {a,b}
    function automatic logic truth(input logic [2:0] op, input logic [1:0] v);
        logic [3:0] tt;
        case (op)
            3'd0:    tt = 4'b1000;
            3'd1:    tt = 4'b1110;
            3'd2:    tt = 4'b0111;
            3'd3:    tt = 4'b0001;
            3'd4:    tt = 4'b0110;
            3'd5:    tt = 4'b1001;
            3'd6:    tt = 4'b0011;
            default: tt = 4'b0000;
        endcase
        return tt[v];
    endfunction

    function automatic logic lu_model(input int mode, input logic [2:0] op, input logic [1:0] v);
        if (mode == 1) return 1'b0;
        if (mode == 2 && op == 3'd4) return truth(3'd5, v);
        if (mode == 2 && op == 3'd5) return truth(3'd4, v);
        return truth(op, v);
    endfunction

    always_comb lu_y = lu_model(lu_mode, lu_op, {lu_a, lu_b});

    task automatic run_sweep(input int mode, input logic hold, input string name);
        exp_t       e;
        int         j;
        int         idx;
        logic [2:0] eop;
        logic [1:0] evec;
        lu_mode = mode;
        e.err = 0; e.fop = 3'd0; e.fvec = 2'd0; e.nvec = 28;
        for (int i = 0; i < 28; i++) begin
            eop  = 3'(i / 4);
            evec = 2'(i % 4);
            if (lu_model(mode, eop, evec) !== truth(eop, evec)) begin
                if (e.err == 0) begin
                    e.fop  = eop;
                    e.fvec = evec;
                end
                e.err++;
`ifdef SELFTEST_STOP_ON_FAIL_EN
                e.nvec = i + 1;
                break;
`endif
            end
        end
        e.pass = (e.err == 0);
        sb_q.push_back(e);

        if (!start) begin
            @(negedge clk);
            start = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        if (!hold) start = 1'b0;

        j = 0;
        while (done !== 1'b1 && j < 200) begin
            n_cmp++;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL %s busy j=%0d: got %b want 1", name, j, busy);
            end
            if (j < 2 * e.nvec) begin
                idx  = j / 2;
                eop  = 3'(idx / 4);
                evec = 2'(idx % 4);
                n_cmp++;
                if ({lu_op, lu_a, lu_b} !== {eop, evec}) begin
                    n_fail++;
                    $display("FAIL %s vector j=%0d: got %0d/%b%b want %0d/%b",
                             name, j, lu_op, lu_a, lu_b, eop, evec);
                end
            end
            if (j == 0) begin
                n_cmp++;
                if ({err_cnt, fail_op, fail_vec, pass} !== '0) begin
                    n_fail++;
                    $display("FAIL %s cleared: got err=%0d op=%0d vec=%0d pass=%b want 0",
                             name, err_cnt, fail_op, fail_vec, pass);
                end
            end
            @(negedge clk);
            j++;
        end

        n_cmp++;
        if (j != 2 * e.nvec) begin
            n_fail++;
            $display("FAIL %s latency: got %0d want %0d", name, j, 2 * e.nvec);
        end

        e = sb_q.pop_front();
        n_cmp++;
        if (err_cnt !== ERR_W'(e.err)) begin
            n_fail++;
            $display("FAIL %s err_cnt: got %0d want %0d", name, err_cnt, e.err);
        end
        n_cmp++;
        if (fail_op !== e.fop || fail_vec !== e.fvec) begin
            n_fail++;
            $display("FAIL %s fail_op/vec: got %0d/%0d want %0d/%0d",
                     name, fail_op, fail_vec, e.fop, e.fvec);
        end
        n_cmp++;
        if (pass !== e.pass) begin
            n_fail++;
            $display("FAIL %s pass: got %b want %b", name, pass, e.pass);
        end
        n_cmp++;
        if ({busy, lu_op, lu_a, lu_b} !== 6'd0) begin
            n_fail++;
            $display("FAIL %s done_outputs: got busy=%b op=%0d a=%b b=%b want 0",
                     name, busy, lu_op, lu_a, lu_b);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({lu_op, lu_a, lu_b, busy, done, pass, err_cnt, fail_op, fail_vec} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got op=%0d a=%b b=%b busy=%b done=%b pass=%b err=%0d want 0",
                     lu_op, lu_a, lu_b, busy, done, pass, err_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_clean();
        run_sweep(0, 1'b0, "clean");
    endtask

    task automatic test_stuck0();
        run_sweep(1, 1'b0, "stuck0");
    endtask

    task automatic test_swap();
        run_sweep(2, 1'b0, "xor_swap");
    endtask

    task automatic test_mid_reset();
        lu_mode = 1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({lu_op, lu_a, lu_b, busy, done, pass, err_cnt, fail_op, fail_vec} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: got op=%0d a=%b b=%b busy=%b err=%0d fop=%0d want 0",
                     lu_op, lu_a, lu_b, busy, err_cnt, fail_op);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep(0, 1'b0, "post_reset");
    endtask

    task automatic test_back_to_back();
        run_sweep(1, 1'b1, "held_start");
        run_sweep(0, 1'b0, "restart_from_done");
    endtask

    initial begin
        test_reset();
        test_clean();
        test_stuck0();
        test_swap();
        test_mid_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/gate_selftest_ctrl.md
Name: gate_selftest_ctrl

Overview:
- Sequencer that exhaustively self-tests a shared 7-function logic unit (AND, OR, NAND, NOR, XOR, XNOR, NOT).
- Drives the unit's opcode and operands, waits for settling, then compares the unit's output against an internal truth table.
- Reports the error count, the first failing op/vector, and pass/done status.
- Sits between a test/boot controller (start/done handshake) and the logic unit under test.

Parameters:
- SETTLE_CYC, 1, cycles to wait after a vector is applied before sampling lu_y; legal range 1..15.
- ERR_W, 5, width of err_cnt; must be ≥5 so the count covers all 28 vectors.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle or level request to begin a sweep.
- lu_op  out  3  opcode to the logic unit: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT (on lu_a); 7 is never driven.
- lu_a  out  1  operand A.
- lu_b  out  1  operand B.
- lu_y  in  1  logic unit result, combinational from lu_op/lu_a/lu_b.
- busy  out  1  high while a sweep is in progress.
- done  out  1  sticky high after the sweep completes, until the next start or reset.
- pass  out  1  done && (err_cnt == 0).
- err_cnt  out  ERR_W  number of mismatches, saturating at all-ones.
- fail_op  out  3  opcode of the first mismatch; 0 if there is none.
- fail_vec  out  2  vector {a,b} of the first mismatch; 0 if there is none.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; every output is 0, including lu_op, lu_a, lu_b, busy, done, pass, err_cnt, fail_op and fail_vec. The internal op/vec/settle counters are also 0. Reset mid-sweep aborts immediately; no partial result is retained.
- FSM states and transitions:
  - IDLE: start=1 clears err_cnt, fail_op, fail_vec and done. It then registers op=0, vec=0 onto lu_op/lu_a/lu_b (lu_a=vec[1], lu_b=vec[0]), sets busy=1 and moves to SETTLE.
  - SETTLE: the settle counter counts SETTLE_CYC cycles, then the FSM moves to CHECK. lu_op/lu_a/lu_b are held stable.
  - CHECK: on this cycle's edge lu_y is compared with the expected value.
    - On a mismatch, err_cnt increments (saturating). If it is the first mismatch, fail_op and fail_vec are captured.
    - Next vector order: vec increments; when vec wraps 3→0, op increments.
    - If op was 6 and vec was 3, the FSM goes to DONE. Otherwise the next vector is registered and the FSM returns to SETTLE.
  - DONE: busy=0, done=1, and pass is valid. lu_op/lu_a/lu_b return to 0. start=1 restarts exactly as from IDLE, in the same cycle.
- Expected values: AND a&b, OR a|b, NAND ~(a&b), NOR ~(a|b), XOR a^b, XNOR ~(a^b), NOT ~a (lu_b is still swept but ignored).
- Timing: each vector takes SETTLE_CYC+1 cycles. If start is sampled at edge k, done rises at edge k+28*(SETTLE_CYC+1), which is k+56 for the default.
- start while busy=1 is ignored; the sweep is not restarted.
- err_cnt and fail_* are stable whenever done=1. pass is 0 whenever done=0.

Optional Feature:
- Macro: SELFTEST_STOP_ON_FAIL_EN.
- Defined: the first mismatch in CHECK goes directly to DONE (err_cnt=1, fail_op/fail_vec captured, pass=0), and the remaining vectors are skipped.
- Undefined: the full 28-vector sweep always runs and all mismatches are counted.

Test Plan:
- Correct logic unit model, SETTLE_CYC=1, start pulsed at edge k → busy high for k..k+55; done=1 and pass=1 at k+56; err_cnt=0, fail_op=0, fail_vec=0.
- lu_y stuck-at-0 → err_cnt=14, fail_op=0 (AND), fail_vec=3, pass=0; lu_op/lu_a/lu_b traverse all 28 vectors in op-major order.
- Model with XOR/XNOR swapped → err_cnt=8, fail_op=4, fail_vec=0.
- rst_n pulled low at edge k+20 mid-sweep → all outputs 0 immediately (asynchronously); a fresh start after release gives a full clean run with done at +56.
- start held high through the sweep and again in DONE → no restart while busy; start in DONE clears the results and begins a new sweep with lu_op=0, lu_a=0, lu_b=0.
- SELFTEST_STOP_ON_FAIL_EN defined, stuck-at-0 model → done at k+8 (vector index 3), err_cnt=1, fail_op=0, fail_vec=3.
